param_datapath: RTL
===================

# param_datapath

Parametrised successor to the Phase 1 bus datapath. It provides a single shared bus and a configurable GPR file with binary-encoded selects, plus PC, IR, MAR, MDR, Y, HI, LO and Zhigh/Zlow. The ALU gains an iterative signed multiply/divide engine with a start/busy/done handshake, and the bus gains a sticky conflict detector. It sits between the control unit and memory; the control unit drives every in/out strobe.

## Interface
- WIDTH, 32, data width of every register and the bus (Z is 2*WIDTH).
- NREGS, 16, number of GPRs; select width SW = $clog2(NREGS).
- R0_ZERO, 1, when 1 GPR0 reads as 0 and writes to it are dropped.

- clock  in  1  single clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- Rin_en, Rout_en  in  1  GPR write / bus-drive enables.
- Rin_sel, Rout_sel  in  SW  GPR write / read index.
- PCin, PCout, IRin, IRout, MARin, MARout, Yin, Yout, MDRin, MDRout, HIin, HIout, LOin, LOout  in  1 each  load / bus-drive strobes.
- Zlowin, Zhighin, Zlowout, Zhighout  in  1 each  Z half load / drive.
- Read  in  1  MDR source select: 1 = Mdatain, 0 = bus.
- Mdatain  in  WIDTH  memory read data.
- ALUop  in  4  operation code.
- alu_start  in  1  launches MUL/DIV.
- alu_busy  out  1  iterative engine active.
- alu_done  out  1  one-cycle pulse when the iterative result is in Z.
- div_by_zero  out  1  registered; set on DIV with divisor 0, cleared on next start.
- bus_error  out  1  sticky multiple-driver flag.
- bus_q, pc_q, ir_q, mar_q, mdr_q  out  WIDTH  observation of bus and registers.

## Operation
- Bus: the value of the single asserted source; 0 when no source is asserted. An asserted Rout_en counts as one source. With two or more sources asserted, the bus is 0 and bus_error sets at the next edge. bus_error holds until clear.
- Rout_sel >= NREGS reads 0. Rin_sel >= NREGS drops the write.
- All loads are edge-triggered from the bus. MDR loads from the Read mux. Zlow/Zhigh load from the ALU result halves.
- ALU A operand = Y; B operand = bus. Combinational ops, each yielding a 2*WIDTH result (upper half 0 unless noted):
  - 0 ADD, 1 SUB, 2 AND, 3 OR.
  - 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL; shift amount = B[$clog2(WIDTH)-1:0].
  - 9 NEG (of B), 10 NOT (of B).
  - 11 MUL, 12 DIV: iterative only.
  - 13-15: result 0.
- Iterative engine FSM: IDLE -> RUN -> FIX -> IDLE.
  - IDLE -> RUN: alu_start=1 with ALUop 11 or 12. Y and bus are captured as signed operands and their magnitudes taken.
  - RUN: WIDTH shift-add (MUL) or restoring shift-subtract (DIV) steps, one per cycle.
  - FIX: apply signs and write both Z halves. MUL: Z = full 2*WIDTH signed product. DIV: Zlow = quotient truncated toward zero, Zhigh = remainder with the sign of the dividend.
- DIV by 0: Zlow = all ones, Zhigh = dividend, div_by_zero = 1.
- While busy: alu_start, Zlowin and Zhighin are ignored; all other transfers proceed normally.
- alu_start with ALUop outside 11/12: ignored.

## Timing
- Reset (clear=1, asynchronous): every register, Z, FSM (-> IDLE), alu_busy, alu_done, div_by_zero and bus_error go to 0 immediately. Clear during RUN/FIX aborts the operation; Z stays 0.
- Register load latency: 1 edge. The bus and ALU are combinational within a cycle.
- Start sampled at edge t0. alu_busy = 1 after t0 through edge t0+WIDTH+1. At edge t0+WIDTH+1, Z is updated, alu_busy falls and alu_done = 1 for exactly one cycle.
- A new alu_start in the alu_done cycle is accepted (back-to-back).
- Zlowin in the same cycle as the FIX write: the engine wins.

## Test plan
- Reset mid-MUL: assert clear at cycle 5 of the operation -> alu_busy = 0, Zlow = Zhigh = 0, alu_done never pulses.
- GPR/bus transfer: Mdatain = 0x12 with Read, MDRin; then MDRout, Rin_sel = 3 -> R3 = 0x12. Write R0 = 0x55 with R0_ZERO = 1 -> reading R0 gives 0.
- ADD: Y = 7, bus = R3 = 0x12, ALUop = 0, Zlowin -> Zlow = 0x19, Zhigh = 0. SHRA: Y = 0x80000000, B = 4 -> Zlow = 0xF8000000.
- MUL (WIDTH = 32): Y = -3, bus = 0x7FFFFFFF, alu_start -> after 34 edges Z = 0xFFFFFFFE_80000003, alu_done pulses once, busy for 33 cycles.
- DIV: Y = -7, B = 2 -> Zlow = -3, Zhigh = -1. Then B = 0 -> Zlow = 0xFFFFFFFF, Zhigh = 0xFFFFFFF9, div_by_zero = 1.
- Bus conflict: PCout and Yout asserted together -> bus_q = 0 that cycle, bus_error = 1 at the next edge and held until clear.

Source files
------------

// File: rtl/param_datapath.sv
// Shared-bus datapath: GPR file, PC/IR/MAR/MDR/Y/HI/LO, Z pair, and a combinational ALU
// backed by an iterative signed multiply/divide engine with a start/busy/done handshake.
module param_datapath #(
   parameter int WIDTH   = 32,
   parameter int NREGS   = 16,
   parameter bit R0_ZERO = 1'b1,
   localparam int SW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             Rin_en,
   input  logic             Rout_en,
   input  logic [SW-1:0]    Rin_sel,
   input  logic [SW-1:0]    Rout_sel,
   input  logic             PCin,
   input  logic             PCout,
   input  logic             IRin,
   input  logic             IRout,
   input  logic             MARin,
   input  logic             MARout,
   input  logic             Yin,
   input  logic             Yout,
   input  logic             MDRin,
   input  logic             MDRout,
   input  logic             HIin,
   input  logic             HIout,
   input  logic             LOin,
   input  logic             LOout,
   input  logic             Zlowin,
   input  logic             Zhighin,
   input  logic             Zlowout,
   input  logic             Zhighout,
   input  logic             Read,
   input  logic [WIDTH-1:0] Mdatain,
   input  logic [3:0]       ALUop,
   input  logic             alu_start,
   output logic             alu_busy,
   output logic             alu_done,
   output logic             div_by_zero,
   output logic             bus_error,
   output logic [WIDTH-1:0] bus_q,
   output logic [WIDTH-1:0] pc_q,
   output logic [WIDTH-1:0] ir_q,
   output logic [WIDTH-1:0] mar_q,
   output logic [WIDTH-1:0] mdr_q
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [3:0] OP_MUL = 4'd11;
   localparam logic [3:0] OP_DIV = 4'd12;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      return (v < 0) ? -v : v;
   endfunction

   logic [WIDTH-1:0] gpr [NREGS];
   logic [WIDTH-1:0] pc, ir, mar, mdr, y, hi, lo, zlow, zhigh;
   logic [WIDTH-1:0] gpr_rd, bus;
   logic [9:0]       srcs;
   logic             multi;

   always_comb begin
      gpr_rd = '0;
      if (int'(Rout_sel) < NREGS && !(R0_ZERO && Rout_sel == '0))
         gpr_rd = gpr[Rout_sel];
      srcs  = {Rout_en, PCout, IRout, MARout, Yout, MDRout, HIout, LOout, Zlowout, Zhighout};
      multi = $countones(srcs) > 1;
      bus   = '0;
      if (!multi)
         bus = ({WIDTH{Rout_en}}  & gpr_rd) | ({WIDTH{PCout}}    & pc)    |
               ({WIDTH{IRout}}    & ir)     | ({WIDTH{MARout}}   & mar)   |
               ({WIDTH{Yout}}     & y)      | ({WIDTH{MDRout}}   & mdr)   |
               ({WIDTH{HIout}}    & hi)     | ({WIDTH{LOout}}    & lo)    |
               ({WIDTH{Zlowout}}  & zlow)   | ({WIDTH{Zhighout}} & zhigh);
   end

   // Combinational ALU: A = Y, B = bus
   logic signed [WIDTH-1:0]   a_s;
   logic [SHW-1:0]            shamt;
   logic [2*WIDTH-1:0]        alu_res, rot;

   always_comb begin
      a_s     = y;
      shamt   = bus[SHW-1:0];
      rot     = '0;
      alu_res = '0;
      case (ALUop)
         4'd0:  alu_res[WIDTH-1:0] = y + bus;
         4'd1:  alu_res[WIDTH-1:0] = y - bus;
         4'd2:  alu_res[WIDTH-1:0] = y & bus;
         4'd3:  alu_res[WIDTH-1:0] = y | bus;
         4'd4:  alu_res[WIDTH-1:0] = y >> shamt;
         4'd5:  alu_res[WIDTH-1:0] = a_s >>> shamt;
         4'd6:  alu_res[WIDTH-1:0] = y << shamt;
         4'd7: begin
            rot = {y, y} >> shamt;
            alu_res[WIDTH-1:0] = rot[WIDTH-1:0];
         end
         4'd8: begin
            rot = {y, y} << shamt;
            alu_res[WIDTH-1:0] = rot[2*WIDTH-1:WIDTH];
         end
         4'd9:  alu_res[WIDTH-1:0] = -bus;
         4'd10: alu_res[WIDTH-1:0] = ~bus;
         default: ;
      endcase
   end

   // Iterative engine datapath: acc_lo holds the multiplier / growing quotient
   state_t           state;
   logic [SHW-1:0]   cnt;
   logic             op_div, sign_a, sign_b;
   logic [WIDTH-1:0] dividend, b_mag, acc_hi, acc_lo;
   logic [WIDTH:0]   mul_sum, div_shift, div_rem;
   logic             div_ge;
   logic [2*WIDTH-1:0] prod, mul_z;
   logic [WIDTH-1:0] quot, rem;

   always_comb begin
      mul_sum   = {1'b0, acc_hi} + {1'b0, {WIDTH{acc_lo[0]}} & b_mag};
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, b_mag};
      div_rem   = div_shift - {1'b0, b_mag};
      prod      = {acc_hi, acc_lo};
      mul_z     = (sign_a ^ sign_b) ? -prod : prod;
      quot      = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
      rem       = sign_a ? -acc_hi : acc_hi;
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state       <= IDLE;
         alu_busy    <= 1'b0;
         alu_done    <= 1'b0;
         div_by_zero <= 1'b0;
         cnt         <= '0;
         op_div      <= 1'b0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         dividend    <= '0;
         b_mag       <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         zlow        <= '0;
         zhigh       <= '0;
      end else begin
         alu_done <= 1'b0;
         case (state)
            IDLE: begin
               if (Zlowin)  zlow  <= alu_res[WIDTH-1:0];
               if (Zhighin) zhigh <= alu_res[2*WIDTH-1:WIDTH];
               if (alu_start && (ALUop == OP_MUL || ALUop == OP_DIV)) begin
                  state       <= RUN;
                  alu_busy    <= 1'b1;
                  div_by_zero <= 1'b0;
                  cnt         <= '0;
                  op_div      <= (ALUop == OP_DIV);
                  sign_a      <= y[WIDTH-1];
                  sign_b      <= bus[WIDTH-1];
                  dividend    <= y;
                  b_mag       <= mag(bus);
                  acc_hi      <= '0;
                  acc_lo      <= mag(y);
               end
            end
            RUN: begin
               if (op_div) begin
                  acc_hi <= div_ge ? div_rem[WIDTH-1:0] : div_shift[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
               end else begin
                  acc_hi <= mul_sum[WIDTH:1];
                  acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == SHW'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               state    <= IDLE;
               alu_busy <= 1'b0;
               alu_done <= 1'b1;
               if (!op_div) begin
                  {zhigh, zlow} <= mul_z;
               end else if (b_mag == '0) begin
                  zlow        <= '1;
                  zhigh       <= dividend;
                  div_by_zero <= 1'b1;
               end else begin
                  zlow  <= quot;
                  zhigh <= rem;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus-loaded registers and the sticky conflict flag
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
         pc        <= '0;
         ir        <= '0;
         mar       <= '0;
         mdr       <= '0;
         y         <= '0;
         hi        <= '0;
         lo        <= '0;
         bus_error <= 1'b0;
      end else begin
         if (Rin_en && int'(Rin_sel) < NREGS && !(R0_ZERO && Rin_sel == '0))
            gpr[Rin_sel] <= bus;
         if (PCin)  pc  <= bus;
         if (IRin)  ir  <= bus;
         if (MARin) mar <= bus;
         if (Yin)   y   <= bus;
         if (HIin)  hi  <= bus;
         if (LOin)  lo  <= bus;
         if (MDRin) mdr <= Read ? Mdatain : bus;
         if (multi) bus_error <= 1'b1;
      end
   end

   assign bus_q = bus;
   assign pc_q  = pc;
   assign ir_q  = ir;
   assign mar_q = mar;
   assign mdr_q = mdr;

endmodule
